// File: rtl/fib_pkg.sv
// Shared definitions for the forward/reverse Fibonacci-style accumulator.
package fib_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    REV  = 2'd2,
    DONE = 2'd3
  } fib_state_t;

  localparam int FIB_WIDTH = 16;
  localparam int FIB_LIMIT = 300;
  localparam int FIB_DEPTH = 32;

endpackage

// File: rtl/sel_lifo.sv
// 1-bit-wide stack recording the selector history of the forward phase.
module sel_lifo #(
  parameter int DEPTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       din,
  output logic                       dout,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic          mem_q [DEPTH];
  logic [CW-1:0] count_q;

  // Occupancy: push and pop are never requested together by the controller.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_q <= '0;
    end else if (push) begin
      count_q <= count_q + CW'(1);
    end else if (pop) begin
      count_q <= count_q - CW'(1);
    end
  end

  // Storage holds data only, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[AW'(count_q)] <= din;
    end
  end

  assign dout  = mem_q[AW'(count_q - CW'(1))];
  assign count = count_q;

endmodule

// File: rtl/fib_unwind.sv
// Runs the bounded accumulator forward, then undoes every step using the
// recorded selector bits so that x, y, i and j return to zero.
module fib_unwind
  import fib_pkg::*;
#(
  parameter int WIDTH = FIB_WIDTH,
  parameter int LIMIT = FIB_LIMIT,
  parameter int DEPTH = FIB_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       selector,
  output logic [WIDTH-1:0]           x,
  output logic [WIDTH-1:0]           y,
  output logic [WIDTH-1:0]           i,
  output logic [WIDTH-1:0]           j,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       busy,
  output logic                       done
);

  localparam int               CW      = $clog2(DEPTH + 1);
  localparam logic [WIDTH-1:0] LIMIT_W = WIDTH'(LIMIT);
  localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO     = WIDTH'(2);

  fib_state_t       state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d, i_q, i_d, j_q, j_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             lifo_push, lifo_pop, lifo_clear, lifo_dout;
  logic [CW-1:0]    lifo_count;

  sel_lifo #(.DEPTH(DEPTH)) u_lifo (
    .clk   (clk),
    .rst   (rst),
    .clear (lifo_clear),
    .push  (lifo_push),
    .pop   (lifo_pop),
    .din   (selector),
    .dout  (lifo_dout),
    .count (lifo_count)
  );

  // Next-state and step arithmetic; a reverse pop subtracts exactly what the
  // matching forward step added, using the pre-decrement x and y.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    i_d        = i_q;
    j_d        = j_q;
    busy_d     = busy_q;
    done_d     = done_q;
    lifo_push  = 1'b0;
    lifo_pop   = 1'b0;
    lifo_clear = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = FWD;
          x_d        = '0;
          y_d        = '0;
          i_d        = '0;
          j_d        = '0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          lifo_clear = 1'b1;
        end
      end
      FWD: begin
        if ((j_q < LIMIT_W) && (lifo_count < DEPTH_C)) begin
          x_d       = x_q + ONE;
          y_d       = y_q + ONE;
          i_d       = i_q + x_q + ONE;
          j_d       = j_q + y_q + (selector ? ONE : TWO);
          lifo_push = 1'b1;
        end else begin
          state_d = REV;
        end
      end
      REV: begin
        if (lifo_count != '0) begin
          x_d      = x_q - ONE;
          y_d      = y_q - ONE;
          i_d      = i_q - x_q;
          j_d      = j_q - y_q - (lifo_dout ? {WIDTH{1'b0}} : ONE);
          lifo_pop = 1'b1;
        end else begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  // State, accumulators and registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      i_q     <= i_d;
      j_q     <= j_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign x     = x_q;
  assign y     = y_q;
  assign i     = i_q;
  assign j     = j_q;
  assign depth = lifo_count;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: doc/fib_unwind.md
# fib_unwind

Forward/reverse twin of the bounded Fibonacci-style accumulator (x, y, i, j). It first runs the recurrence forward under the `selector` input and records every selector bit in a LIFO. It then runs the recurrence backward, popping those bits to undo each step exactly, and must return all four registers to zero. It sits beside the forward accumulator in the arithmetic property-mining set and carries the invariants `j >= i` and `x == y` in both directions.

## Interface
Parameters:
- `WIDTH`, 16: width of x, y, i, j.
- `LIMIT`, 300: forward phase steps only while `j < LIMIT`.
- `DEPTH`, 32: LIFO capacity, and the maximum number of forward steps.

Ports:
- `clk`: input, 1. Single clock; all state changes on posedge.
- `rst`: input, 1. Synchronous, active-high; sampled on posedge clk.
- `start`: input, 1. Begins a run when sampled high in IDLE or DONE.
- `selector`: input, 1. Step selector, sampled in FWD.
- `x`, `y`, `i`, `j`: output, WIDTH each. Accumulator registers.
- `depth`: output, $clog2(DEPTH+1). Current LIFO occupancy.
- `busy`: output, 1. High in FWD or REV.
- `done`: output, 1. High in DONE.

## Operation
- States: IDLE, FWD, REV, DONE. Reset forces IDLE, x=y=i=j=0, depth=0, busy=0, done=0.
- IDLE/DONE, `start`=1: clear x, y, i, j and the LIFO, then go to FWD. `start` is ignored in FWD and REV.
- FWD, when `j < LIMIT` and `depth < DEPTH`:
  - x += 1; y += 1; i += x_old + 1.
  - j += y_old + 1 if `selector`=1, else j += y_old + 2.
  - Push `selector`; depth += 1.
- FWD, otherwise: no step that cycle; go to REV.
- REV, `depth > 0`: pop bit s, then
  - x -= 1; y -= 1;
  - i -= x_cur;
  - j -= y_cur + (s ? 0 : 1);
  - x_cur and y_cur are the pre-decrement values; depth -= 1.
- REV, `depth == 0`: go to DONE. x, y, i, j must already be 0.
- DONE: hold all values until `start` or `rst`.
- Arithmetic is modulo 2^WIDTH. With the default parameters no wrap can occur: max j = 324.
- Invariants, every cycle:
  - `j >= i`;
  - `x == y`;
  - `x == depth` in FWD and REV;
  - in DONE, x = y = i = j = 0.

## Timing
- `start` sampled at edge N puts the block in FWD with zeros after edge N.
- Each FWD step or REV pop takes 1 cycle.
- Both FWD→REV and REV→DONE consume one non-stepping cycle.
- Total run for k steps: 2k + 2 cycles from the FWD entry edge to the DONE entry edge.
- `busy` and `done` are decoded from registered state, with no combinational path from inputs.
- `rst` mid-FWD or mid-REV: the next cycle is IDLE with all outputs 0 and the LIFO emptied.
- `rst` and `start` high together: `rst` wins.

## Structure
- Package `fib_pkg`: state enum `fib_state_t` {IDLE, FWD, REV, DONE}, default `WIDTH`/`LIMIT`/`DEPTH` constants.
- Sub-module `sel_lifo`: 1-bit-wide, DEPTH-entry stack.
  - Ports: push, pop, din, dout, count, clear.
  - Synchronous clear; simultaneous push and pop is not required and is never issued by the FSM.
- The top level holds the FSM and the four accumulators.

## Test plan
- `selector`=1 constant, `start` pulse: 24 steps to x=y=24, i=300, j=300. Then 24 pops back to all-zero. `done` is high 50 cycles after FWD entry.
- `selector`=0 constant: 24 steps to x=y=24, i=300, j=324. The reverse phase returns all-zero and DONE is reached.
- Random `selector` each cycle: `j >= i` and `x == y` hold every cycle. The final state is all-zero, and REV length equals FWD step count.
- `DEPTH`=4, `selector`=1: stops at depth=4 with x=4, i=10, j=10, because the LIFO-full limit is reached before LIMIT. Unwinds to zero.
- `rst` asserted at 3rd REV cycle: next cycle is IDLE, all outputs 0, depth=0. A new `start` then runs normally.
- `start` pulsed during FWD and REV: no effect. `start` in DONE restarts from zero.
